// File: rtl/cache_controller.sv
// Cache controller FSM: zero-wait hits in CHECK, dirty-victim writeback, then line fill.
// Hit latency 0 cycles; miss latency = writeback cycles + fill cycles + 1.
// The CPU request is held until mem_resp; physical memory stalls by withholding pmem_resp.
module cache_controller #(
    parameter int CTR_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    input  logic             mem_write,
    output logic             mem_resp,
    output logic             pmem_read,
    output logic             pmem_write,
    input  logic             pmem_resp,
    input  logic             hit,
    input  logic             dirty_out,
    output logic             tag_load,
    output logic             valid_load,
    output logic             dirty_load,
    output logic             dirty_in,
    output logic [1:0]       writing,
    input  logic             ctr_clear,
    output logic [CTR_W-1:0] hit_count,
    output logic [CTR_W-1:0] miss_count,
    output logic [CTR_W-1:0] wb_count
);

    typedef enum logic [1:0] {CHECK, WRITEBACK, ALLOCATE} state_t;

    state_t state;
    logic   req;
    logic   hit_inc;
    logic   miss_inc;
    logic   wb_inc;

    assign req = mem_read | mem_write;

    // Outputs depend on the live inputs so a hit completes in the cycle it is presented.
    always_comb begin
        mem_resp   = 1'b0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        tag_load   = 1'b0;
        valid_load = 1'b0;
        dirty_load = 1'b0;
        dirty_in   = 1'b0;
        writing    = 2'b11;
        hit_inc    = 1'b0;
        miss_inc   = 1'b0;
        wb_inc     = 1'b0;
        if (!rst) begin
            case (state)
                CHECK: begin
                    if (req && hit) begin
                        mem_resp = 1'b1;
                        hit_inc  = 1'b1;
                        if (mem_write) begin
                            writing    = 2'b01;
                            dirty_load = 1'b1;
                            dirty_in   = 1'b1;
                        end
                    end else if (req) begin
                        miss_inc = 1'b1;
                        wb_inc   = dirty_out;
                    end
                end
                WRITEBACK: begin
                    pmem_write = 1'b1;
                    if (pmem_resp) begin
                        dirty_load = 1'b1;
                    end
                end
                ALLOCATE: begin
                    pmem_read = 1'b1;
                    if (pmem_resp) begin
                        writing    = 2'b00;
                        tag_load   = 1'b1;
                        valid_load = 1'b1;
                        dirty_load = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CHECK;
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            case (state)
                CHECK: begin
                    if (miss_inc) begin
                        state <= dirty_out ? WRITEBACK : ALLOCATE;
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) begin
                        state <= ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    if (pmem_resp) begin
                        state <= CHECK;
                    end
                end
                default: state <= CHECK;
            endcase

            if (ctr_clear) begin
                hit_count  <= '0;
                miss_count <= '0;
                wb_count   <= '0;
            end else begin
                if (hit_inc && hit_count != '1) begin
                    hit_count <= hit_count + CTR_W'(1);
                end
                if (miss_inc && miss_count != '1) begin
                    miss_count <= miss_count + CTR_W'(1);
                end
                if (wb_inc && wb_count != '1) begin
                    wb_count <= wb_count + CTR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with 4-bit counters; each scenario task checks inline.
module tb_cache_controller;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         mem_read;
    logic         mem_write;
    logic         mem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic         pmem_resp;
    logic         hit;
    logic         dirty_out;
    logic         tag_load;
    logic         valid_load;
    logic         dirty_load;
    logic         dirty_in;
    logic [1:0]   writing;
    logic         ctr_clear;
    logic [W-1:0] hit_count;
    logic [W-1:0] miss_count;
    logic [W-1:0] wb_count;

    int checks;
    int failures;

    cache_controller #(.CTR_W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_resp   (mem_resp),
        .pmem_read  (pmem_read),
        .pmem_write (pmem_write),
        .pmem_resp  (pmem_resp),
        .hit        (hit),
        .dirty_out  (dirty_out),
        .tag_load   (tag_load),
        .valid_load (valid_load),
        .dirty_load (dirty_load),
        .dirty_in   (dirty_in),
        .writing    (writing),
        .ctr_clear  (ctr_clear),
        .hit_count  (hit_count),
        .miss_count (miss_count),
        .wb_count   (wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge, then let inputs change away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
        hit = 1'b0; dirty_out = 1'b0; ctr_clear = 1'b0;
        tick(); tick();
        rst = 1'b0;
        settle();
        checks++; if (hit_count !== 4'd0) begin failures++; $display("FAIL reset_hit_count got=%0d exp=0", hit_count); end
        checks++; if (miss_count !== 4'd0 || wb_count !== 4'd0) begin failures++; $display("FAIL reset_miss_wb got=%0d/%0d exp=0/0", miss_count, wb_count); end
        checks++; if ({mem_resp, pmem_read, pmem_write, tag_load, valid_load, dirty_load, dirty_in, writing} !== 9'b000000011) begin
            failures++; $display("FAIL reset_outputs got=%b exp=000000011", {mem_resp, pmem_read, pmem_write, tag_load, valid_load, dirty_load, dirty_in, writing}); end
    endtask

    task automatic test_read_hit();
        mem_read = 1'b1; hit = 1'b1;
        settle();
        checks++; if (mem_resp !== 1'b1 || writing !== 2'b11 || dirty_load !== 1'b0) begin
            failures++; $display("FAIL read_hit resp/writing/dload got=%b/%b/%b exp=1/11/0", mem_resp, writing, dirty_load); end
        tick();
        mem_read = 1'b0; hit = 1'b0;
        settle();
        checks++; if (hit_count !== 4'd1) begin failures++; $display("FAIL read_hit_count got=%0d exp=1", hit_count); end
        checks++; if (mem_resp !== 1'b0) begin failures++; $display("FAIL idle_resp got=%b exp=0", mem_resp); end
    endtask

    task automatic test_write_hit();
        mem_write = 1'b1; hit = 1'b1;
        settle();
        checks++; if ({mem_resp, writing, dirty_load, dirty_in} !== 5'b10111) begin
            failures++; $display("FAIL write_hit resp,writing,dload,din got=%b exp=10111", {mem_resp, writing, dirty_load, dirty_in}); end
        tick();
        mem_read = 1'b1;
        settle();
        checks++; if ({mem_resp, writing, dirty_in} !== 4'b1011) begin
            failures++; $display("FAIL rd_wr_as_write got=%b exp=1011", {mem_resp, writing, dirty_in}); end
        tick();
        mem_read = 1'b0; mem_write = 1'b0; hit = 1'b0; pmem_resp = 1'b1;
        settle();
        checks++; if (hit_count !== 4'd3) begin failures++; $display("FAIL write_hit_count got=%0d exp=3", hit_count); end
        tick();
        pmem_resp = 1'b0;
        settle();
        checks++; if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || miss_count !== 4'd0) begin
            failures++; $display("FAIL pmem_resp_in_check got=%b%b miss=%0d exp=00 miss=0", pmem_read, pmem_write, miss_count); end
    endtask

    task automatic test_clean_read_miss();
        int rd_cycles;
        rd_cycles = 0;
        mem_read = 1'b1; hit = 1'b0; dirty_out = 1'b0;
        settle();
        checks++; if (mem_resp !== 1'b0 || pmem_read !== 1'b0) begin
            failures++; $display("FAIL clean_miss_check got resp=%b pread=%b exp=0/0", mem_resp, pmem_read); end
        tick();
        for (int c = 1; c <= 3; c++) begin
            pmem_resp = (c == 3);
            settle();
            if (pmem_read === 1'b1) rd_cycles++;
            checks++; if (pmem_write !== 1'b0) begin failures++; $display("FAIL clean_miss_pwrite c=%0d got=%b exp=0", c, pmem_write); end
            if (c < 3) begin
                checks++; if (writing !== 2'b11 || tag_load !== 1'b0) begin
                    failures++; $display("FAIL alloc_wait c=%0d writing=%b tload=%b exp=11/0", c, writing, tag_load); end
            end else begin
                checks++; if ({writing, tag_load, valid_load, dirty_load, dirty_in} !== 6'b001110) begin
                    failures++; $display("FAIL fill_cycle got=%b exp=001110", {writing, tag_load, valid_load, dirty_load, dirty_in}); end
            end
            checks++; if (mem_resp !== 1'b0) begin failures++; $display("FAIL clean_miss_early_resp c=%0d got=%b exp=0", c, mem_resp); end
            tick();
        end
        pmem_resp = 1'b0; hit = 1'b1;
        settle();
        checks++; if (rd_cycles !== 3) begin failures++; $display("FAIL pmem_read_cycles got=%0d exp=3", rd_cycles); end
        checks++; if (mem_resp !== 1'b1 || pmem_read !== 1'b0) begin
            failures++; $display("FAIL clean_miss_resp got resp=%b pread=%b exp=1/0", mem_resp, pmem_read); end
        tick();
        mem_read = 1'b0; hit = 1'b0;
        settle();
        checks++; if (miss_count !== 4'd1 || wb_count !== 4'd0 || hit_count !== 4'd4) begin
            failures++; $display("FAIL clean_miss_counts got m=%0d w=%0d h=%0d exp=1/0/4", miss_count, wb_count, hit_count); end
    endtask

    task automatic test_dirty_write_miss();
        mem_write = 1'b1; hit = 1'b0; dirty_out = 1'b1;
        tick();
        settle();
        checks++; if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || dirty_load !== 1'b0) begin
            failures++; $display("FAIL wb_c1 got pw=%b pr=%b dl=%b exp=1/0/0", pmem_write, pmem_read, dirty_load); end
        checks++; if (miss_count !== 4'd2 || wb_count !== 4'd1) begin
            failures++; $display("FAIL dirty_miss_counts got m=%0d w=%0d exp=2/1", miss_count, wb_count); end
        tick();
        pmem_resp = 1'b1;
        settle();
        checks++; if ({pmem_write, pmem_read, dirty_load, dirty_in, tag_load} !== 5'b10100) begin
            failures++; $display("FAIL wb_resp_cycle got=%b exp=10100", {pmem_write, pmem_read, dirty_load, dirty_in, tag_load}); end
        tick();
        pmem_resp = 1'b0; dirty_out = 1'b0;
        settle();
        checks++; if (pmem_read !== 1'b1 || pmem_write !== 1'b0) begin
            failures++; $display("FAIL alloc_after_wb got pr=%b pw=%b exp=1/0", pmem_read, pmem_write); end
        tick();
        pmem_resp = 1'b1;
        settle();
        checks++; if ({pmem_read, writing, tag_load, valid_load, dirty_load, dirty_in} !== 7'b1001110) begin
            failures++; $display("FAIL dirty_fill_cycle got=%b exp=1001110", {pmem_read, writing, tag_load, valid_load, dirty_load, dirty_in}); end
        tick();
        pmem_resp = 1'b0; hit = 1'b1;
        settle();
        checks++; if ({mem_resp, writing, dirty_load, dirty_in} !== 5'b10111) begin
            failures++; $display("FAIL dirty_miss_write_hit got=%b exp=10111", {mem_resp, writing, dirty_load, dirty_in}); end
        tick();
        mem_write = 1'b0; hit = 1'b0;
        settle();
        checks++; if (hit_count !== 4'd5 || miss_count !== 4'd2 || wb_count !== 4'd1) begin
            failures++; $display("FAIL dirty_miss_final got h=%0d m=%0d w=%0d exp=5/2/1", hit_count, miss_count, wb_count); end
    endtask

    task automatic test_saturation();
        ctr_clear = 1'b1;
        tick();
        ctr_clear = 1'b0;
        settle();
        checks++; if (hit_count !== 4'd0 || miss_count !== 4'd0 || wb_count !== 4'd0) begin
            failures++; $display("FAIL ctr_clear got h=%0d m=%0d w=%0d exp=0/0/0", hit_count, miss_count, wb_count); end
        mem_read = 1'b1; hit = 1'b1;
        for (int i = 0; i < 17; i++) tick();
        settle();
        checks++; if (hit_count !== 4'd15) begin failures++; $display("FAIL hit_saturate got=%0d exp=15", hit_count); end
        ctr_clear = 1'b1;
        tick();
        ctr_clear = 1'b0; mem_read = 1'b0; hit = 1'b0;
        settle();
        checks++; if (hit_count !== 4'd0) begin failures++; $display("FAIL clear_over_inc got=%0d exp=0", hit_count); end
    endtask

    task automatic test_reset_mid_alloc();
        mem_read = 1'b1; hit = 1'b0; dirty_out = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        settle();
        checks++; if ({pmem_read, pmem_write, tag_load, valid_load, dirty_load, mem_resp, writing} !== 8'b00000011) begin
            failures++; $display("FAIL rst_in_alloc got=%b exp=00000011", {pmem_read, pmem_write, tag_load, valid_load, dirty_load, mem_resp, writing}); end
        tick();
        rst = 1'b0; mem_read = 1'b0;
        settle();
        checks++; if (miss_count !== 4'd0 || pmem_read !== 1'b0) begin
            failures++; $display("FAIL after_rst got miss=%0d pr=%b exp=0/0", miss_count, pmem_read); end
        mem_read = 1'b1; hit = 1'b1;
        settle();
        checks++; if (mem_resp !== 1'b1) begin failures++; $display("FAIL rst_back_to_check got=%b exp=1", mem_resp); end
        tick();
        mem_read = 1'b0; hit = 1'b0;
    endtask

    task automatic test_abandoned_request();
        mem_read = 1'b1; hit = 1'b0; dirty_out = 1'b0;
        tick();
        mem_read = 1'b0;
        settle();
        checks++; if (pmem_read !== 1'b1) begin failures++; $display("FAIL abandon_still_fill got=%b exp=1", pmem_read); end
        tick();
        pmem_resp = 1'b1;
        settle();
        checks++; if (tag_load !== 1'b1 || writing !== 2'b00) begin
            failures++; $display("FAIL abandon_fill got tl=%b wr=%b exp=1/00", tag_load, writing); end
        tick();
        pmem_resp = 1'b0;
        settle();
        checks++; if (pmem_read !== 1'b0 || mem_resp !== 1'b0) begin
            failures++; $display("FAIL abandon_return got pr=%b resp=%b exp=0/0", pmem_read, mem_resp); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_read_hit();
        test_write_hit();
        test_clean_read_miss();
        test_dirty_write_miss();
        test_saturation();
        test_reset_mid_alloc();
        test_abandoned_request();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
